memory_cycle: RTL and testbench
===============================

# memory_cycle

Memory stage of the pipelined RV32 core. It consumes the EX/MEM pipeline outputs and performs word loads and stores to an internal data memory. It also decodes a memory-mapped SPI master region and runs byte transfers on the SPI pins, stalling the pipeline while an access must wait for the shifter. It registers the MEM/WB pipeline outputs for the writeback stage.

## Interface
- DMEM_WORDS, 1024: data memory depth in 32-bit words (power of two).
- CLK_DIV, 4: clk cycles per SCLK half-period (≥1).
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- RegWriteM, MemWriteM  in  1  EX/MEM control.
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4.
- RD_M  in  5  destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  in  32  EX/MEM data; ALU_ResultM is the byte address.
- spi_miso  in  1  SPI data in.
- RegWriteW  out  1; ResultSrcW  out  2; RD_W  out  5; PCPlus4W, ALU_ResultW, ReadDataW  out  32: the MEM/WB register.
- StallM  out  1  combinational; the hazard unit uses it to freeze PC, IF/ID, ID/EX and EX/MEM.
- spi_sclk, spi_mosi, spi_cs_n  out  1  SPI mode 0 master pins.

## Operation
- Decode: spi_sel = (ALU_ResultM[31:28]==4'h4). Word index = ALU_ResultM[log2(DMEM_WORDS)+1:2]. Address bits [1:0] are ignored.
- Load = (ResultSrcM==2'b01).
- Data memory write: synchronous on clk when MemWriteM & ~spi_sel & ~StallM. Read is combinational. Contents are not reset.
- SPI registers are decoded on ALU_ResultM[3:2]:
  - 0 DATA. A write starts a transfer of WriteDataM[7:0]. A read returns {24'b0, rx_data} and clears rx_valid.
  - 1 STATUS. A read returns {30'b0, rx_valid, busy}. Writes are ignored.
  - Other offsets read 0 and ignore writes.
- StallM = spi_sel & (ALU_ResultM[3:2]==0) & (MemWriteM | Load) & busy. STATUS accesses never stall.
- Read data mux: spi_sel selects the SPI register value; otherwise the data memory word.
- MEM/WB register, updated each clk:
  - When StallM=1: bubble. RegWriteW<=0; other W fields keep their previous values.
  - Otherwise: all M fields pass through, and ReadDataW <= read mux.
- SPI FSM states: IDLE → ASSERT → SHIFT → HOLD → IDLE.
  - IDLE: cs_n=1, sclk=0, busy=0. An accepted DATA write loads tx_shift, sets cs_n=0 and drives mosi=tx[7], then moves to ASSERT.
  - ASSERT: lasts CLK_DIV cycles. It then enters SHIFT and raises sclk.
  - SHIFT: sclk toggles every CLK_DIV cycles, giving 8 rising and 8 falling edges.
    - On each rising edge, miso is sampled into rx_shift LSB-first-in, so the byte is assembled MSB first.
    - On each falling edge except the 8th, mosi advances to the next bit, MSB first.
    - After the 8th falling edge (sclk=0) the FSM enters HOLD.
  - HOLD: lasts CLK_DIV cycles with cs_n still 0. On exit: cs_n=1, rx_data<=rx_shift, rx_valid<=1, state IDLE.
  - busy = (state != IDLE).
- Simultaneous events: a DATA read in the same cycle that HOLD exits is stalled, because busy is still 1. It completes the next cycle and returns the new byte. A DATA write in IDLE while rx_valid=1 starts a transfer and leaves rx_valid unchanged.
- Reset (asynchronous, including mid-transfer):
  - FSM returns to IDLE.
  - cs_n=1, sclk=0, mosi=0.
  - busy, rx_valid, rx_data and the shift registers clear to 0.
  - All W outputs clear to 0.

## Timing
- Load and store latency: 1 cycle. ReadDataW is valid the cycle after the M-stage instruction.
- An SPI transfer occupies the bus for 18×CLK_DIV clk cycles from the accepting edge to the return to IDLE; 72 cycles at the default CLK_DIV.
- Stall duration equals the remaining busy cycles. The stalled instruction completes on the first edge with busy=0.
- StallM has no registered delay and depends on same-cycle M inputs and FSM state.
- SPI pins are registered outputs and glitch-free.

## Test plan
- Store then load: store 0xDEADBEEF to 0x0000_0010, then load the same address. ReadDataW=0xDEADBEEF and RegWriteW=1 one cycle later. A load from 0x10 with ResultSrcM=00 still passes ALU_ResultW=0x10.
- SPI byte transfer: write 0xA5 to 0x4000_0000 with miso looped to mosi and CLK_DIV=4. cs_n is low for 72 cycles, mosi carries 1,0,1,0,0,1,0,1 across 8 sclk pulses, then STATUS=0x2 and a DATA read returns 0x000000A5 with STATUS becoming 0x0.
- Back-to-back writes: a second DATA write one cycle after the first. StallM=1 for 71 cycles with RegWriteW=0 bubbles, then the second transfer starts on the next edge.
- STATUS polling during a transfer: reads of 0x4000_0004 return 0x1 with StallM=0 throughout.
- Reset mid-transfer: deassert rst in the 30th cycle of SHIFT. Immediately cs_n=1, sclk=0, STATUS=0, RegWriteW=0. After release, a new 0x3C transfer completes normally.
- SPI-region store isolation: a store to 0x4000_0008 leaves data memory index 2 unchanged, and a load of 0x4000_0008 returns 0.

Source files
------------

// File: rtl/memory_cycle.sv
// memory_cycle: RV32 memory stage. Handles word loads and stores to a local
// data memory, runs a memory-mapped SPI mode-0 master, and registers the
// MEM/WB pipeline outputs.
module memory_cycle #(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    input  logic        spi_miso,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        StallM,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_SHIFT  = 2'd2,
        S_HOLD   = 2'd3
    } spi_state_e;

    // Data memory (not reset)
    logic [31:0] dmem [DMEM_WORDS];

    // SPI master state
    spi_state_e    state_q;
    logic [DW-1:0] div_q;
    logic [3:0]    half_q;
    logic [7:0]    tx_shift_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          cs_n_q;

    // MEM/WB register
    logic          reg_write_w_q;
    logic [1:0]    result_src_w_q;
    logic [4:0]    rd_w_q;
    logic [31:0]   pc_plus4_w_q;
    logic [31:0]   alu_result_w_q;
    logic [31:0]   read_data_w_q;

    // Decode and combinational controls
    logic          spi_sel_c;
    logic          load_c;
    logic          data_acc_c;
    logic          busy_c;
    logic          spi_start_c;
    logic          rx_clear_c;
    logic          dmem_we_c;
    logic [AW-1:0] word_idx_c;
    logic [31:0]   spi_rdata_c;
    logic [31:0]   read_mux_c;
    logic          unused_addr_c;

    assign spi_sel_c   = (ALU_ResultM[31:28] == 4'h4);
    assign load_c      = (ResultSrcM == 2'b01);
    assign data_acc_c  = spi_sel_c & (ALU_ResultM[3:2] == 2'd0);
    assign busy_c      = (state_q != S_IDLE);
    assign StallM      = data_acc_c & (MemWriteM | load_c) & busy_c;
    assign spi_start_c = data_acc_c & MemWriteM & ~busy_c;
    assign rx_clear_c  = data_acc_c & load_c & ~busy_c;
    assign dmem_we_c   = MemWriteM & ~spi_sel_c & ~StallM;
    assign word_idx_c  = ALU_ResultM[AW+1:2];
    // Address bits outside the decoded fields are intentionally ignored
    assign unused_addr_c = ^ALU_ResultM;

    // SPI register read value selected by the word offset
    always_comb begin
        spi_rdata_c = 32'd0;
        case (ALU_ResultM[3:2])
            2'd0:    spi_rdata_c = {24'd0, rx_data_q};
            2'd1:    spi_rdata_c = {30'd0, rx_valid_q, busy_c};
            default: spi_rdata_c = 32'd0;
        endcase
    end

    assign read_mux_c = spi_sel_c ? spi_rdata_c : dmem[word_idx_c];

    // Synchronous data memory write port
    always_ff @(posedge clk) begin
        if (dmem_we_c) begin
            dmem[word_idx_c] <= WriteDataM;
        end
    end

    // SPI master FSM: IDLE -> ASSERT -> SHIFT (16 half periods) -> HOLD -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            half_q     <= 4'd0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            if (rx_clear_c) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (spi_start_c) begin
                        tx_shift_q <= WriteDataM[7:0];
                        mosi_q     <= WriteDataM[7];
                        cs_n_q     <= 1'b0;
                        div_q      <= '0;
                        state_q    <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (div_q == DIV_LAST) begin
                        div_q      <= '0;
                        half_q     <= 4'd0;
                        sclk_q     <= 1'b1;
                        rx_shift_q <= {rx_shift_q[6:0], spi_miso};
                        state_q    <= S_SHIFT;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q  <= '0;
                        half_q <= half_q + 4'd1;
                        if (half_q == 4'd15) begin
                            state_q <= S_HOLD;
                        end else if (sclk_q) begin
                            sclk_q <= 1'b0;
                            // No new bit after the 8th falling edge
                            if (half_q != 4'd14) begin
                                mosi_q     <= tx_shift_q[6];
                                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                            end
                        end else begin
                            sclk_q     <= 1'b1;
                            rx_shift_q <= {rx_shift_q[6:0], spi_miso};
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_HOLD: begin
                    if (div_q == DIV_LAST) begin
                        div_q      <= '0;
                        cs_n_q     <= 1'b1;
                        mosi_q     <= 1'b0;
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // MEM/WB register; a stall inserts a bubble by dropping RegWrite
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 2'd0;
            rd_w_q         <= 5'd0;
            pc_plus4_w_q   <= 32'd0;
            alu_result_w_q <= 32'd0;
            read_data_w_q  <= 32'd0;
        end else if (StallM) begin
            reg_write_w_q <= 1'b0;
        end else begin
            reg_write_w_q  <= RegWriteM;
            result_src_w_q <= ResultSrcM;
            rd_w_q         <= RD_M;
            pc_plus4_w_q   <= PCPlus4M;
            alu_result_w_q <= ALU_ResultM;
            read_data_w_q  <= read_mux_c;
        end
    end

    assign RegWriteW   = reg_write_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign RD_W        = rd_w_q;
    assign PCPlus4W    = pc_plus4_w_q;
    assign ALU_ResultW = alu_result_w_q;
    assign ReadDataW   = read_data_w_q;
    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;
    assign spi_cs_n    = cs_n_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: table-driven memory vectors plus hand-written
// SPI transfer, stall, polling and reset sequences (CLK_DIV = 4).
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        spi_miso;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
    logic        StallM, spi_sclk, spi_mosi, spi_cs_n;

    int checks = 0;
    int errors = 0;

    // MISO looped back to MOSI
    assign spi_miso = spi_mosi;

    memory_cycle #(.DMEM_WORDS(1024), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM), .spi_miso(spi_miso),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .StallM(StallM), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wd;
        logic [31:0] alu;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [4:0] rd, input logic [31:0] pc4,
                         input logic [31:0] wd, input logic [31:0] alu);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        PCPlus4M    = pc4;
        WriteDataM  = wd;
        ALU_ResultM = alu;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int low, rises, poll_bad, stall, bubble_bad;
        logic [7:0] mbits;
        logic prev_sclk;

        vecs[0]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h104, 32'hDEADBEEF, 32'h0000_0010, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 5'd5,  32'h108, 32'h0,        32'h0000_0010, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 5'd6,  32'h10C, 32'h0,        32'h0000_0010, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h110, 32'h12345678, 32'h0000_0008, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 5'd7,  32'h114, 32'h0,        32'h0000_000B, 1'b1, 32'h12345678};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h118, 32'hCAFEF00D, 32'h4000_0008, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 5'd8,  32'h11C, 32'h0,        32'h4000_0008, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 5'd9,  32'h120, 32'h0,        32'h0000_0008, 1'b1, 32'h12345678};
        vecs[8]  = '{1'b1, 1'b0, 2'b01, 5'd10, 32'h124, 32'h0,        32'h4000_0004, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'b10, 5'd31, 32'h200, 32'h0,        32'h0000_0044, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'b01, 5'd11, 32'h128, 32'h0,        32'h0000_1010, 1'b1, 32'hDEADBEEF};

        // Reset state
        nop();
        tick();
        tick();
        chk("rst_regw", 32'(RegWriteW), 32'd0);
        chk("rst_rdata", ReadDataW, 32'd0);
        chk("rst_pc4", PCPlus4W, 32'd0);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Memory vectors: W fields pass through one cycle later
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd, vecs[i].pc4, vecs[i].wd, vecs[i].alu);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(StallM), 32'd0);
            tick();
            chk($sformatf("vec%0d_regw", i), 32'(RegWriteW), 32'(vecs[i].rw));
            chk($sformatf("vec%0d_rsrc", i), 32'(ResultSrcW), 32'(vecs[i].rs));
            chk($sformatf("vec%0d_rd", i), 32'(RD_W), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_pc4", i), PCPlus4W, vecs[i].pc4);
            chk($sformatf("vec%0d_alu", i), ALU_ResultW, vecs[i].alu);
            if (vecs[i].chk_rd) begin
                chk($sformatf("vec%0d_rdata", i), ReadDataW, vecs[i].exp_rd);
            end
        end

        // SPI 0xA5 transfer while polling STATUS every cycle
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'd0, 32'h0000_00A5, 32'h4000_0000);
        #1;
        chk("a5_start_stall", 32'(StallM), 32'd0);
        tick();
        chk("a5_cs_low", 32'(spi_cs_n), 32'd0);
        drive(1'b1, 1'b0, 2'b01, 5'd3, 32'd0, 32'd0, 32'h4000_0004);
        low = 1;
        rises = 0;
        poll_bad = 0;
        mbits = 8'd0;
        prev_sclk = spi_sclk;
        for (int k = 0; k < 200; k++) begin
            if (spi_cs_n) break;
            #1;
            if (StallM) poll_bad++;
            tick();
            if (ReadDataW !== 32'h1) poll_bad++;
            if (!spi_cs_n) low++;
            if (spi_sclk && !prev_sclk) begin
                rises++;
                mbits = {mbits[6:0], spi_mosi};
            end
            prev_sclk = spi_sclk;
        end
        chk("a5_cs_low_cycles", 32'(low), 32'd72);
        chk("a5_sclk_rises", 32'(rises), 32'd8);
        chk("a5_mosi_bits", 32'(mbits), 32'h0000_00A5);
        chk("a5_status_poll_bad", 32'(poll_bad), 32'd0);
        tick();
        chk("a5_status_done", ReadDataW, 32'h2);
        drive(1'b1, 1'b0, 2'b01, 5'd4, 32'd0, 32'd0, 32'h4000_0000);
        #1;
        chk("a5_read_stall", 32'(StallM), 32'd0);
        tick();
        chk("a5_read_data", ReadDataW, 32'h0000_00A5);
        chk("a5_read_regw", 32'(RegWriteW), 32'd1);
        drive(1'b1, 1'b0, 2'b01, 5'd3, 32'd0, 32'd0, 32'h4000_0004);
        tick();
        chk("a5_status_cleared", ReadDataW, 32'h0);

        // Back-to-back DATA writes: second issued one cycle after the first is accepted
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'd0, 32'h0000_005A, 32'h4000_0000);
        tick();
        nop();
        tick();
        drive(1'b1, 1'b1, 2'b00, 5'd7, 32'd0, 32'h0000_0096, 32'h4000_0000);
        stall = 0;
        bubble_bad = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!StallM) break;
            stall++;
            tick();
            if (RegWriteW !== 1'b0) bubble_bad++;
        end
        chk("b2b_stall_cycles", 32'(stall), 32'd71);
        chk("b2b_bubbles", 32'(bubble_bad), 32'd0);
        tick();
        chk("b2b_second_regw", 32'(RegWriteW), 32'd1);
        chk("b2b_second_cs", 32'(spi_cs_n), 32'd0);
        drive(1'b1, 1'b0, 2'b01, 5'd3, 32'd0, 32'd0, 32'h4000_0004);
        tick();
        chk("b2b_status_valid_busy", ReadDataW, 32'h3);

        // Reset in the 30th cycle of SHIFT
        nop();
        repeat (31) tick();
        drive(1'b1, 1'b0, 2'b00, 5'd9, 32'd0, 32'd0, 32'h0000_0020);
        tick();
        chk("mid_pre_cs", 32'(spi_cs_n), 32'd0);
        chk("mid_pre_regw", 32'(RegWriteW), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(spi_cs_n), 32'd1);
        chk("mid_rst_sclk", 32'(spi_sclk), 32'd0);
        chk("mid_rst_mosi", 32'(spi_mosi), 32'd0);
        chk("mid_rst_regw", 32'(RegWriteW), 32'd0);
        chk("mid_rst_alu", ALU_ResultW, 32'd0);
        nop();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b01, 5'd3, 32'd0, 32'd0, 32'h4000_0004);
        tick();
        chk("mid_status_after", ReadDataW, 32'h0);

        // 0x3C transfer with a DATA read issued right away; it stalls until IDLE
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'd0, 32'h0000_003C, 32'h4000_0000);
        tick();
        drive(1'b1, 1'b0, 2'b01, 5'd12, 32'd0, 32'd0, 32'h4000_0000);
        stall = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!StallM) break;
            stall++;
            tick();
        end
        chk("x3c_read_stall_cycles", 32'(stall), 32'd72);
        chk("x3c_cs_high", 32'(spi_cs_n), 32'd1);
        tick();
        chk("x3c_read_data", ReadDataW, 32'h0000_003C);
        chk("x3c_read_regw", 32'(RegWriteW), 32'd1);
        chk("x3c_read_rd", 32'(RD_W), 32'd12);
        drive(1'b1, 1'b0, 2'b01, 5'd3, 32'd0, 32'd0, 32'h4000_0004);
        tick();
        chk("x3c_status_cleared", ReadDataW, 32'h0);
        nop();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
